// File: rtl/toggle_cov_pkg.sv
// Shared types and constants for the toggle-coverage event generator and its sinks.
package toggle_cov_pkg;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } arm_state_e;

  localparam int COVER_TOTAL = 13;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/toggle_bit_tracker.sv
// Per-bit toggle tracker: remembers the last sample, rise/fall history and sticky
// coverage, and registers the one-cycle completion pulse for its lane.
module toggle_bit_tracker #(
  parameter bit NEW_ONLY = 1'b1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic arm_i,
  input  logic enable_i,
  input  logic clear_i,
  input  logic sig_i,
  output logic valid_o,
  output logic covered_o,
  output logic newly_covered_o
);

  logic prev_q, prev_d;
  logic seen_r_q, seen_r_d;
  logic seen_f_q, seen_f_d;
  logic covered_q, covered_d;
  logic valid_q, valid_d;
  logic sample, rise, fall, done;

  always_comb begin
    sample          = arm_i & enable_i;
    rise            = sample & ~prev_q & sig_i;
    fall            = sample & prev_q & ~sig_i;
    done            = sample & (seen_r_q | rise) & (seen_f_q | fall);
    newly_covered_o = done & ~covered_q & ~clear_i;

    prev_d    = enable_i ? sig_i : prev_q;
    seen_r_d  = seen_r_q | rise;
    seen_f_d  = seen_f_q | fall;
    covered_d = covered_q | done;
    valid_d   = NEW_ONLY ? (done & ~covered_q) : done;

    // Re-arm the pair detector so every subsequent rise+fall fires again.
    if (done && !NEW_ONLY) begin
      seen_r_d = 1'b0;
      seen_f_d = 1'b0;
    end

    if (clear_i) begin
      seen_r_d  = 1'b0;
      seen_f_d  = 1'b0;
      covered_d = 1'b0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q    <= 1'b0;
      seen_r_q  <= 1'b0;
      seen_f_q  <= 1'b0;
      covered_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      seen_r_q  <= seen_r_d;
      seen_f_q  <= seen_f_d;
      covered_q <= covered_d;
      valid_q   <= valid_d;
    end
  end

  assign valid_o   = valid_q;
  assign covered_o = covered_q;

endmodule

// File: rtl/toggle_detect.sv
// Toggle-event generator: arms on the first enabled sample, then emits per-lane
// completion pulses plus sticky coverage and a covered-bit count.
module toggle_detect
  import toggle_cov_pkg::*;
#(
  parameter int WIDTH    = COVER_TOTAL,
  parameter bit NEW_ONLY = 1'b1,
  localparam int CW      = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CW-1:0]    count
);

  arm_state_e       state_q, state_d;
  logic             arm;
  logic [WIDTH-1:0] newly;
  logic [CW-1:0]    add_d;
  logic [CW-1:0]    count_q, count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= UNARMED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    case (state_q)
      UNARMED: if (enable) state_d = ARMED;
      ARMED:   arm = 1'b1;
      default: state_d = UNARMED;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_bit_tracker #(.NEW_ONLY(NEW_ONLY)) u_trk (
      .clock_i         (clock),
      .reset_i         (reset),
      .arm_i           (arm),
      .enable_i        (enable),
      .clear_i         (clear),
      .sig_i           (signal[i]),
      .valid_o         (valid[i]),
      .covered_o       (covered[i]),
      .newly_covered_o (newly[i])
    );
  end

  // Newly covered bits are already masked by covered, so the sum stays within WIDTH.
  always_comb begin
    add_d = '0;
    for (int i = 0; i < WIDTH; i++) add_d = add_d + CW'(newly[i]);
    count_d = clear ? '0 : count_q + add_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_toggle_detect.sv
// Scoreboard bench for toggle_detect: one NEW_ONLY=1 and one NEW_ONLY=0 instance.
module tb_toggle_detect;

  typedef struct packed {
    logic [12:0] v;
    logic [12:0] c;
    logic [3:0]  n;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en1 = 1'b0, en0 = 1'b0, clr = 1'b0;
  logic [12:0] signal = '0;
  logic [12:0] valid1, covered1, valid0, covered0;
  logic [3:0]  count1, count0;

  exp_t q1[$];
  exp_t q0[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  toggle_detect #(.WIDTH(13), .NEW_ONLY(1'b1)) dut1 (
    .clock(clock), .reset(reset), .enable(en1), .clear(clr), .signal(signal),
    .valid(valid1), .covered(covered1), .count(count1));

  toggle_detect #(.WIDTH(13), .NEW_ONLY(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(en0), .clear(clr), .signal(signal),
    .valid(valid0), .covered(covered0), .count(count0));

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_cmp(input string name, input exp_t act, input exp_t q[$], output exp_t rest[$]);
    rest = q;
    vectors++;
    if (rest.size() == 0) begin
      miscompares++;
      $display("FAIL %s unexpected pulse: valid=0x%0h covered=0x%0h count=%0d expected no pulse",
               name, act.v, act.c, act.n);
    end else begin
      exp_t e;
      e = rest.pop_front();
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: valid=0x%0h covered=0x%0h count=%0d expected valid=0x%0h covered=0x%0h count=%0d",
                 name, act.v, act.c, act.n, e.v, e.c, e.n);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset && valid1 != '0) begin
      exp_t r;
      exp_t t[$];
      mon_cmp("dut1_pulse", '{v: valid1, c: covered1, n: count1}, q1, t);
      q1 = t;
    end
    if (!reset && valid0 != '0) begin
      exp_t r;
      exp_t t[$];
      mon_cmp("dut0_pulse", '{v: valid0, c: covered0, n: count0}, q0, t);
      q0 = t;
    end
  end

  task automatic drive(input logic [12:0] s, input logic e1, input logic e0, input logic c);
    signal = s; en1 = e1; en0 = e0; clr = c;
    @(posedge clock);
    #1;
  endtask

  task automatic a1(input logic [12:0] s, input logic c = 1'b0);
    drive(s, 1'b1, 1'b0, c);
  endtask

  task automatic a0(input logic [12:0] s);
    drive(s, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic settle(input string name);
    drive(signal, 1'b0, 1'b0, 1'b0);
    drive(signal, 1'b0, 1'b0, 1'b0);
    chk({name, "_q1_drained"}, q1.size(), 0);
    chk({name, "_q0_drained"}, q0.size(), 0);
  endtask

  initial begin
    #12;
    chk("reset_valid",   valid1,   0);
    chk("reset_covered", covered1, 0);
    chk("reset_count",   count1,   0);
    reset = 1'b0;

    // priming then a single bit-0 toggle
    a1(13'h0000);
    a1(13'h0001);
    q1.push_back('{v: 13'h0001, c: 13'h0001, n: 4'd1});
    a1(13'h0000);
    settle("prime");
    chk("prime_covered", covered1, 13'h0001);
    chk("prime_count",   count1,   1);

    // repeated toggles: no new pulses
    for (int k = 0; k < 3; k++) begin
      a1(13'h0001);
      a1(13'h0000);
    end
    settle("repeat");
    chk("repeat_count", count1, 1);

    // all bits complete together
    a1(13'h0000, 1'b1);
    chk("clear_count", count1, 0);
    a1(13'h1FFF);
    q1.push_back('{v: 13'h1FFF, c: 13'h1FFF, n: 4'd13});
    a1(13'h0000);
    a1(13'h1FFF);
    a1(13'h0000);
    settle("all");
    chk("all_count_sat", count1, 13);

    // transitions while disabled are not observed
    a1(13'h0000, 1'b1);
    drive(13'h1FFF, 1'b0, 1'b0, 1'b0);
    drive(13'h0000, 1'b0, 1'b0, 1'b0);
    a1(13'h0000);
    settle("gate");
    chk("gate_covered", covered1, 0);
    chk("gate_count",   count1,   0);

    // clear collides with a bit-5 completion
    a1(13'h0020);
    a1(13'h0000, 1'b1);
    chk("collide_valid",   valid1,   0);
    chk("collide_covered", covered1, 0);
    chk("collide_count",   count1,   0);
    a1(13'h0020);
    q1.push_back('{v: 13'h0020, c: 13'h0020, n: 4'd1});
    a1(13'h0000);
    settle("bit5");

    // async reset while a pulse is on the output
    a1(13'h0007);
    q1.push_back('{v: 13'h0007, c: 13'h0027, n: 4'd4});
    a1(13'h0000);
    #6;
    reset = 1'b1;
    #1;
    chk("areset_valid",   valid1,   0);
    chk("areset_covered", covered1, 0);
    chk("areset_count",   count1,   0);
    @(negedge clock);
    reset = 1'b0;
    a1(13'h0007);
    a1(13'h0000);
    chk("rearm_count", count1, 0);
    q1.push_back('{v: 13'h0007, c: 13'h0007, n: 4'd3});
    a1(13'h0007);
    settle("rearm");

    // NEW_ONLY=0 instance: one pulse per full pair
    a0(13'h0000);
    for (int k = 0; k < 3; k++) begin
      a0(13'h0001);
      q0.push_back('{v: 13'h0001, c: 13'h0001, n: 4'd1});
      a0(13'h0000);
    end
    settle("every");
    chk("every_count", count0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
